// File: rtl/ram_arb_pkg.sv
// Shared FSM encoding and winner-selection helpers for ram_arbiter.
// Selection helpers cover both the round-robin and RAM_ARB_FIXED_PRI_EN builds.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_REQ = 32;

  // First requesting index strictly after 'last', wrapping modulo num.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int last, input int num);
    int   idx;
    logic found;
    rr_pick = 0;
    found   = 1'b0;
    for (int off = 1; off <= num; off++) begin
      idx = (last + off) % num;
      if (!found && req[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic int fixed_pick(input logic [MAX_REQ-1:0] req, input int num);
    fixed_pick = 0;
    for (int i = num - 1; i >= 0; i--) begin
      if (req[i[4:0]]) fixed_pick = i;
    end
  endfunction

endpackage

// File: rtl/ram_arb_beat_cnt.sv
// Burst beat counter: counts issued beats and flags the final one (beat == len).
module ram_arb_beat_cnt #(
  parameter int LEN_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [LEN_WIDTH-1:0] len,
  output logic [LEN_WIDTH-1:0] beat,
  output logic                 term
);

  // Clear wins over enable so the final beat leaves the counter at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat <= '0;
    end else if (clr) begin
      beat <= '0;
    end else if (en) begin
      beat <= beat + 1'b1;
    end
  end

  assign term = (beat == len);

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one single-port RAM.
// Define RAM_ARB_FIXED_PRI_EN for fixed priority (lowest index wins, no last-grant pointer).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            beat_ack,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [ID_WIDTH-1:0]           rd_id,
  output logic                          done,
  output logic [ID_WIDTH-1:0]           done_id,
  output logic                          busy
);

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat;
  logic                  term;
  logic [ID_WIDTH-1:0]   win;

`ifdef RAM_ARB_FIXED_PRI_EN
  assign win = ID_WIDTH'(fixed_pick(32'(req), NUM_REQ));
`else
  logic [ID_WIDTH-1:0] last_q;

  assign win = ID_WIDTH'(rr_pick(32'(req), int'(last_q), NUM_REQ));

  // The pointer only moves when a burst completes, so an aborted burst leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= ID_WIDTH'(NUM_REQ - 1);
    end else if (state == DONE) begin
      last_q <= id_q;
    end
  end
`endif

  ram_arb_beat_cnt #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_beat_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (~ram_en | term),
    .en   (ram_en),
    .len  (len_q),
    .beat (beat),
    .term (term)
  );

  // Command fields are latched once in IDLE; requester inputs are ignored until the next IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      id_q     <= '0;
      we_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      gnt      <= '0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= '0;
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            id_q   <= win;
            we_q   <= req_we[win];
            base_q <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            len_q  <= req_len[win*LEN_WIDTH +: LEN_WIDTH];
            gnt    <= NUM_REQ'(1) << win;
            ram_en <= 1'b1;
            ram_we <= req_we[win];
            busy   <= 1'b1;
            state  <= BURST;
          end
        end
        BURST: begin
          rd_valid <= ~we_q;
          rd_id    <= id_q;
          if (term) begin
            gnt     <= '0;
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            done    <= 1'b1;
            done_id <= id_q;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write data is a live pass-through of the winner's slice; read data arrives a cycle after its beat.
  assign beat_ack  = gnt & {NUM_REQ{ram_en}};
  assign ram_addr  = ram_en ? base_q + ADDR_WIDTH'(beat) : '0;
  assign ram_wdata = (ram_en && we_q) ? req_wdata[id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign rd_data   = rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized bursts vs a behavioural model.
module tb_ram_arbiter;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LW = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      req, req_we, gnt, beat_ack;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*LW-1:0]   req_len;
  logic [NR*DW-1:0]   req_wdata;
  logic               ram_en, ram_we, rd_valid, done, busy;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_wdata, ram_rdata, rd_data;
  logic [IW-1:0]      rd_id, done_id;

  int vectors = 0;
  int miscompares = 0;
  int model_last = NR - 1;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] wtab    [NR][8];
  logic [2:0]    ack_cnt [NR];

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .beat_ack(beat_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id),
    .done(done), .done_id(done_id), .busy(busy)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a * 40503 + 17);
  endfunction

  // Synchronous single-port RAM with one-cycle read latency.
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = init_word(a);
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // Each requester counts its own beat_acks to present the data of the current beat.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NR; i++) ack_cnt[i] <= 3'd0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (done && done_id == IW'(i)) ack_cnt[i] <= 3'd0;
        else if (beat_ack[i])          ack_cnt[i] <= ack_cnt[i] + 3'd1;
      end
    end
  end

  always_comb begin
    req_wdata = '0;
    for (int i = 0; i < NR; i++) req_wdata[i*DW +: DW] = wtab[i][ack_cnt[i]];
  end

  function automatic int model_pick(input logic [NR-1:0] r, input int last);
    int w;
    w = -1;
`ifdef RAM_ARB_FIXED_PRI_EN
    for (int i = NR - 1; i >= 0; i--) if (r[i]) w = i;
`else
    for (int off = NR; off >= 1; off--) if (r[(last + off) % NR]) w = (last + off) % NR;
`endif
    return w;
  endfunction

  task automatic set_req(input int i, input logic on, input logic we,
                         input logic [AW-1:0] addr, input logic [LW-1:0] len);
    req[i] = on;
    req_we[i] = we;
    req_addr[i*AW +: AW] = addr;
    req_len[i*LW +: LW] = len;
  endtask

  task automatic fill_wtab();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 8; j++) wtab[i][j] = DW'($urandom);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req = '0; req_we = '0; req_addr = '0; req_len = '0;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({gnt, beat_ack, ram_en, ram_we, ram_addr, ram_wdata, rd_valid, rd_data, rd_id, done, done_id, busy} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: gnt=%b ram_en=%b busy=%b done=%b rd_valid=%b, expected all zero", gnt, ram_en, busy, done, rd_valid);
    end
    req = 4'hF;
    @(negedge clk);
    vectors++;
    if ({gnt, ram_en, busy} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: gnt=%b ram_en=%b busy=%b, expected 0", gnt, ram_en, busy);
    end
    req = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({gnt, busy, ram_en} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_no_req: gnt=%b busy=%b ram_en=%b, expected 0", gnt, busy, ram_en);
    end
  endtask

  task automatic test_single_read();
    logic [AW-1:0] a;
    set_req(1, 1'b1, 1'b0, 8'h10, 3'd3);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) req = '0;
      a = 8'h10 + AW'(k);
      vectors++;
      if ({ram_en, ram_we, gnt, ram_addr} !== {1'b1, 1'b0, 4'b0010, a}) begin
        miscompares++;
        $display("[TB] FAIL single_read_beat%0d: en=%b we=%b gnt=%b addr=%h, expected 1 0 0010 %h", k, ram_en, ram_we, gnt, ram_addr, a);
      end
      vectors++;
      if (rd_valid !== (k > 0)) begin
        miscompares++;
        $display("[TB] FAIL single_read_valid%0d: rd_valid=%b, expected %b", k, rd_valid, (k > 0));
      end
      if (k > 0) begin
        vectors++;
        if ({rd_id, rd_data} !== {2'd1, ref_mem[a - 8'd1]}) begin
          miscompares++;
          $display("[TB] FAIL single_read_data%0d: id=%0d data=%h, expected 1 %h", k, rd_id, rd_data, ref_mem[a - 8'd1]);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if ({done, done_id, rd_valid, rd_id, rd_data} !== {1'b1, 2'd1, 1'b1, 2'd1, ref_mem[8'h13]}) begin
      miscompares++;
      $display("[TB] FAIL single_read_done: done=%b id=%0d rd_valid=%b rd_id=%0d data=%h, expected 1 1 1 1 %h", done, done_id, rd_valid, rd_id, rd_data, ref_mem[8'h13]);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, gnt} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL single_read_idle: busy=%b done=%b gnt=%b, expected 0", busy, done, gnt);
    end
    model_last = 1;
  endtask

  task automatic test_write_wrap();
    logic [AW-1:0] a;
    fill_wtab();
    set_req(0, 1'b1, 1'b1, 8'hFE, 3'd2);
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      if (k == 0) req = '0;
      a = 8'hFE + AW'(k);
      vectors++;
      if ({ram_en, ram_we, beat_ack, ram_addr} !== {1'b1, 1'b1, 4'b0001, a}) begin
        miscompares++;
        $display("[TB] FAIL wrap_beat%0d: en=%b we=%b ack=%b addr=%h, expected 1 1 0001 %h", k, ram_en, ram_we, beat_ack, ram_addr, a);
      end
      vectors++;
      if (ram_wdata !== wtab[0][k]) begin
        miscompares++;
        $display("[TB] FAIL wrap_wdata%0d: got %h, expected %h", k, ram_wdata, wtab[0][k]);
      end
      ref_mem[a] = wtab[0][k];
    end
    @(negedge clk);
    vectors++;
    if ({done, done_id, rd_valid, gnt} !== {1'b1, 2'd0, 1'b0, 4'b0}) begin
      miscompares++;
      $display("[TB] FAIL wrap_done: done=%b id=%0d rd_valid=%b gnt=%b, expected 1 0 0 0000", done, done_id, rd_valid, gnt);
    end
    @(negedge clk);
    model_last = 0;
  endtask

  task automatic test_round_robin();
    int n, last_c, exp_w, m_last;
    logic [NR-1:0] prev, oh;
    bit ok;
    req = '0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_last = NR - 1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'($urandom), 3'd0);
    n = 0; last_c = 0; prev = '0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (gnt != '0 && prev == '0) begin
        exp_w = model_pick(4'hF, m_last);
        m_last = exp_w;
        oh = NR'(1) << exp_w;
        vectors++;
        if (gnt !== oh) begin
          miscompares++;
          $display("[TB] FAIL rr_order grant%0d: gnt=%b, expected %b", n, gnt, oh);
        end
        if (n > 0) begin
          vectors++;
          if (c - last_c != 3) begin
            miscompares++;
            $display("[TB] FAIL rr_spacing grant%0d: %0d cycles, expected 3", n, c - last_c);
          end
        end
        last_c = c;
        n++;
        if (n == 5) req = '0;
      end
      prev = gnt;
    end
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("[TB] FAIL rr_timeout: saw %0d grants, expected 5", n);
      req = '0;
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL rr_idle: busy=%b, expected 0", busy);
    end
    model_last = m_last;
  endtask

  task automatic test_mid_deassert();
    logic [AW-1:0] base;
    bit ok;
    base = AW'($urandom);
    set_req(2, 1'b1, 1'b0, base, 3'd7);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 0) set_req(3, 1'b1, 1'b0, AW'($urandom), 3'd0);
      if (k == 2) req[2] = 1'b0;
      vectors++;
      if ({gnt, ram_en, ram_addr} !== {4'b0100, 1'b1, base + AW'(k)}) begin
        miscompares++;
        $display("[TB] FAIL deassert_beat%0d: gnt=%b en=%b addr=%h, expected 0100 1 %h", k, gnt, ram_en, ram_addr, base + AW'(k));
      end
    end
    @(negedge clk);
    vectors++;
    if ({done, done_id, gnt} !== {1'b1, 2'd2, 4'b0}) begin
      miscompares++;
      $display("[TB] FAIL deassert_done: done=%b id=%0d gnt=%b, expected 1 2 0000", done, done_id, gnt);
    end
    @(negedge clk);
    vectors++;
    if ({busy, gnt} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL deassert_holdoff: busy=%b gnt=%b, expected 0 0000", busy, gnt);
    end
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL deassert_next_grant: gnt=%b, expected 1000", gnt);
    end
    req = '0;
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL deassert_idle: busy=%b, expected 0", busy);
    end
    model_last = 3;
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] oh;
    int w;
    bit ok;
    set_req(1, 1'b1, 1'b0, AW'($urandom), 3'd0);
    @(negedge clk);
    req = '0;
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL rmid_pre_grant: gnt=%b, expected 0010", gnt);
    end
    wait_idle(ok);
    model_last = 1;
    set_req(2, 1'b1, 1'b0, AW'($urandom), 3'd7);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) req = '0;
      vectors++;
      if ({gnt, ram_en} !== {4'b0100, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL rmid_beat%0d: gnt=%b en=%b, expected 0100 1", k, gnt, ram_en);
      end
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({gnt, ram_en, busy, rd_valid, done} !== 8'b0) begin
      miscompares++;
      $display("[TB] FAIL rmid_abort: gnt=%b en=%b busy=%b rd_valid=%b done=%b, expected 0", gnt, ram_en, busy, rd_valid, done);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({done, busy} !== 2'b0) begin
        miscompares++;
        $display("[TB] FAIL rmid_no_done: done=%b busy=%b, expected 0 0", done, busy);
      end
    end
    reset = 1'b1;
    model_last = NR - 1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'($urandom), 3'd0);
    @(negedge clk);
    w = model_pick(4'hF, model_last);
    oh = NR'(1) << w;
    vectors++;
    if (gnt !== oh) begin
      miscompares++;
      $display("[TB] FAIL rmid_first_grant: gnt=%b, expected %b", gnt, oh);
    end
    req = '0;
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL rmid_idle: busy=%b, expected 0", busy);
    end
    model_last = w;
  endtask

`ifdef RAM_ARB_FIXED_PRI_EN
  task automatic test_fixed_priority();
    int n;
    logic [NR-1:0] prev;
    bit ok;
    set_req(1, 1'b1, 1'b0, AW'($urandom), 3'd0);
    set_req(3, 1'b1, 1'b0, AW'($urandom), 3'd0);
    n = 0; prev = '0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (gnt != '0 && prev == '0) begin
        vectors++;
        if (gnt !== 4'b0010) begin
          miscompares++;
          $display("[TB] FAIL fixed_grant%0d: gnt=%b, expected 0010", n, gnt);
        end
        n++;
      end
      prev = gnt;
    end
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("[TB] FAIL fixed_timeout: saw %0d grants, expected 4", n);
    end
    req = '0;
    wait_idle(ok);
  endtask
`endif

  task automatic test_random(input int rounds);
    logic [NR-1:0] bits, oh;
    logic [AW-1:0] base, a, prev_a;
    logic [LW-1:0] len;
    logic          we;
    int            w;
    for (int r = 0; r < rounds; r++) begin
      fill_wtab();
      bits = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) set_req(i, bits[i], 1'($urandom), AW'($urandom), LW'($urandom));
      w = model_pick(bits, model_last);
      oh = NR'(1) << w;
      we = req_we[w];
      base = req_addr[w*AW +: AW];
      len = req_len[w*LW +: LW];
      prev_a = '0;
      for (int k = 0; k <= int'(len); k++) begin
        @(negedge clk);
        a = base + AW'(k);
        vectors++;
        if ({gnt, beat_ack, ram_en, ram_we, ram_addr, busy, done} !== {oh, oh, 1'b1, we, a, 1'b1, 1'b0}) begin
          miscompares++;
          $display("[TB] FAIL rnd%0d_beat%0d: gnt=%b ack=%b en=%b we=%b addr=%h busy=%b done=%b, expected %b %b 1 %b %h 1 0",
                   r, k, gnt, beat_ack, ram_en, ram_we, ram_addr, busy, done, oh, oh, we, a);
        end
        vectors++;
        if (rd_valid !== (!we && k > 0)) begin
          miscompares++;
          $display("[TB] FAIL rnd%0d_valid%0d: rd_valid=%b, expected %b", r, k, rd_valid, (!we && k > 0));
        end
        if (!we && k > 0) begin
          vectors++;
          if ({rd_id, rd_data} !== {IW'(w), ref_mem[prev_a]}) begin
            miscompares++;
            $display("[TB] FAIL rnd%0d_rdata%0d: id=%0d data=%h, expected %0d %h", r, k, rd_id, rd_data, w, ref_mem[prev_a]);
          end
        end
        if (we) begin
          vectors++;
          if (ram_wdata !== wtab[w][k]) begin
            miscompares++;
            $display("[TB] FAIL rnd%0d_wdata%0d: got %h, expected %h", r, k, ram_wdata, wtab[w][k]);
          end
          ref_mem[a] = wtab[w][k];
        end
        prev_a = a;
        req = NR'($urandom);
        req_we = NR'($urandom);
        req_addr = (NR*AW)'($urandom);
        req_len = (NR*LW)'($urandom);
      end
      @(negedge clk);
      vectors++;
      if ({done, done_id, gnt, ram_en, busy, rd_valid} !== {1'b1, IW'(w), 4'b0, 1'b0, 1'b1, !we}) begin
        miscompares++;
        $display("[TB] FAIL rnd%0d_done: done=%b id=%0d gnt=%b en=%b busy=%b rd_valid=%b, expected 1 %0d 0000 0 1 %b",
                 r, done, done_id, gnt, ram_en, busy, rd_valid, w, !we);
      end
      if (!we) begin
        vectors++;
        if (rd_data !== ref_mem[prev_a]) begin
          miscompares++;
          $display("[TB] FAIL rnd%0d_last_rdata: got %h, expected %h", r, rd_data, ref_mem[prev_a]);
        end
      end
      req = '0;
      @(negedge clk);
      vectors++;
      if ({busy, done, gnt} !== 6'b0) begin
        miscompares++;
        $display("[TB] FAIL rnd%0d_idle: busy=%b done=%b gnt=%b, expected 0", r, busy, done, gnt);
      end
      model_last = w;
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
    fill_wtab();
    test_reset();
    test_single_read();
    test_write_wrap();
    test_round_robin();
    test_mid_deassert();
    test_reset_mid();
`ifdef RAM_ARB_FIXED_PRI_EN
    test_fixed_priority();
`endif
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
